// File: rtl/mux_cfg_pkg.sv
// Shared constants and types for the mux configuration command controller.
package mux_cfg_pkg;

    localparam logic [7:0] OP_SET    = 8'h01;
    localparam logic [7:0] OP_DIS    = 8'h02;
    localparam logic [7:0] OP_COMMIT = 8'h03;
    localparam logic [7:0] OP_CLEAR  = 8'h04;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_OPCODE  = 2'd1;
    localparam logic [1:0] ERR_RANGE   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StArg0,
        StArg1,
        StExec
    } cfg_state_e;

    function automatic logic is_known_op(logic [7:0] op);
        return (op == OP_SET) || (op == OP_DIS) || (op == OP_COMMIT) || (op == OP_CLEAR);
    endfunction

endpackage

// File: rtl/mux_cfg_timeout.sv
// Idle counter for byte-stream front ends: counts while enabled, clears on demand,
// flags the cycle in which the Limit-th consecutive idle cycle is reached.
module mux_cfg_timeout #(
    parameter int unsigned Limit = 1000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic count_i,
    output logic expire_o
);

    localparam int unsigned CntW = (Limit > 1) ? $clog2(Limit) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_i) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Limit of 0 disables expiry entirely.
    assign expire_o = (Limit != 0) && count_i && !clear_i && (cnt_q == CntW'(Limit - 1));

endmodule

// File: rtl/mux_config_ctrl.sv
// Byte-stream command controller that edits a shadow mux configuration and
// commits it atomically to the live selector/enable outputs.
module mux_config_ctrl
    import mux_cfg_pkg::*;
#(
    parameter int unsigned INPUT_COUNT    = 16,
    parameter int unsigned OUTPUT_COUNT   = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    localparam int unsigned SEL_WIDTH     = $clog2(INPUT_COUNT)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [7:0]                        in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [SEL_WIDTH*OUTPUT_COUNT-1:0] selectors,
    output logic [OUTPUT_COUNT-1:0]           enabled_out,
    output logic                              cmd_done,
    output logic                              cmd_err,
    output logic [1:0]                        err_code,
    output logic                              dirty
);

    localparam int unsigned SelBits = SEL_WIDTH * OUTPUT_COUNT;

    cfg_state_e state_q, state_d;
    logic [7:0] op_q, op_d;
    logic [7:0] arg_o_q, arg_o_d;
    logic [7:0] arg_s_q, arg_s_d;
    logic [1:0] pend_err_q, pend_err_d;

    logic [SelBits-1:0]      shadow_sel_q, shadow_sel_d;
    logic [OUTPUT_COUNT-1:0] shadow_en_q, shadow_en_d;
    logic [SelBits-1:0]      live_sel_q, live_sel_d;
    logic [OUTPUT_COUNT-1:0] live_en_q, live_en_d;

    logic       cmd_done_q, cmd_done_d;
    logic       cmd_err_q, cmd_err_d;
    logic [1:0] err_code_q, err_code_d;

    logic accept, in_arg, expire, o_ok, s_ok;

    assign in_ready = (state_q != StExec);
    assign accept   = in_valid && in_ready;
    assign in_arg   = (state_q == StArg0) || (state_q == StArg1);
    assign o_ok     = {24'd0, arg_o_q} < OUTPUT_COUNT;
    assign s_ok     = {24'd0, arg_s_q} < INPUT_COUNT;

    mux_cfg_timeout #(
        .Limit(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clear_i (accept || !in_arg),
        .count_i (in_arg && !accept),
        .expire_o(expire)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        arg_o_d      = arg_o_q;
        arg_s_d      = arg_s_q;
        pend_err_d   = pend_err_q;
        shadow_sel_d = shadow_sel_q;
        shadow_en_d  = shadow_en_q;
        live_sel_d   = live_sel_q;
        live_en_d    = live_en_q;
        cmd_done_d   = 1'b0;
        cmd_err_d    = 1'b0;
        err_code_d   = ERR_NONE;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d       = in_data;
                    pend_err_d = is_known_op(in_data) ? ERR_NONE : ERR_OPCODE;
                    state_d    = (in_data == OP_SET || in_data == OP_DIS) ? StArg0 : StExec;
                end
            end
            StArg0: begin
                if (accept) begin
                    arg_o_d = in_data;
                    state_d = (op_q == OP_SET) ? StArg1 : StExec;
                end else if (expire) begin
                    pend_err_d = ERR_TIMEOUT;
                    state_d    = StExec;
                end
            end
            StArg1: begin
                if (accept) begin
                    arg_s_d = in_data;
                    state_d = StExec;
                end else if (expire) begin
                    pend_err_d = ERR_TIMEOUT;
                    state_d    = StExec;
                end
            end
            StExec: begin
                state_d = StIdle;
                if (pend_err_q != ERR_NONE) begin
                    cmd_err_d  = 1'b1;
                    err_code_d = pend_err_q;
                end else begin
                    case (op_q)
                        OP_SET: begin
                            if (o_ok && s_ok) begin
                                for (int unsigned i = 0; i < OUTPUT_COUNT; i++) begin
                                    if ({24'd0, arg_o_q} == i) begin
                                        shadow_sel_d[i*SEL_WIDTH +: SEL_WIDTH] =
                                            arg_s_q[SEL_WIDTH-1:0];
                                        shadow_en_d[i] = 1'b1;
                                    end
                                end
                                cmd_done_d = 1'b1;
                            end else begin
                                cmd_err_d  = 1'b1;
                                err_code_d = ERR_RANGE;
                            end
                        end
                        OP_DIS: begin
                            if (o_ok) begin
                                for (int unsigned i = 0; i < OUTPUT_COUNT; i++) begin
                                    if ({24'd0, arg_o_q} == i) begin
                                        shadow_en_d[i] = 1'b0;
                                    end
                                end
                                cmd_done_d = 1'b1;
                            end else begin
                                cmd_err_d  = 1'b1;
                                err_code_d = ERR_RANGE;
                            end
                        end
                        OP_COMMIT: begin
                            live_sel_d = shadow_sel_q;
                            live_en_d  = shadow_en_q;
                            cmd_done_d = 1'b1;
                        end
                        OP_CLEAR: begin
                            shadow_sel_d = '0;
                            shadow_en_d  = '0;
                            cmd_done_d   = 1'b1;
                        end
                        default: begin
                            cmd_err_d  = 1'b1;
                            err_code_d = ERR_OPCODE;
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            op_q         <= '0;
            arg_o_q      <= '0;
            arg_s_q      <= '0;
            pend_err_q   <= ERR_NONE;
            shadow_sel_q <= '0;
            shadow_en_q  <= '0;
            live_sel_q   <= '0;
            live_en_q    <= '0;
            cmd_done_q   <= 1'b0;
            cmd_err_q    <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            arg_o_q      <= arg_o_d;
            arg_s_q      <= arg_s_d;
            pend_err_q   <= pend_err_d;
            shadow_sel_q <= shadow_sel_d;
            shadow_en_q  <= shadow_en_d;
            live_sel_q   <= live_sel_d;
            live_en_q    <= live_en_d;
            cmd_done_q   <= cmd_done_d;
            cmd_err_q    <= cmd_err_d;
            err_code_q   <= err_code_d;
        end
    end

    assign selectors   = live_sel_q;
    assign enabled_out = live_en_q;
    assign cmd_done    = cmd_done_q;
    assign cmd_err     = cmd_err_q;
    assign err_code    = err_code_q;
    // Identical rewrites leave shadow == live, so dirty stays low.
    assign dirty       = (shadow_sel_q != live_sel_q) || (shadow_en_q != live_en_q);

endmodule

// File: tb/tb_mux_config_ctrl.sv
// Directed bench for mux_config_ctrl with a command-level reference model checked every cycle.
module tb_mux_config_ctrl;

    localparam int unsigned IN  = 16;
    localparam int unsigned OUT = 16;
    localparam int unsigned TMO = 8;
    localparam int unsigned SW  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [SW*OUT-1:0] selectors;
    logic [OUT-1:0]    enabled_out;
    logic              cmd_done;
    logic              cmd_err;
    logic [1:0]        err_code;
    logic              dirty;

    mux_config_ctrl #(
        .INPUT_COUNT   (IN),
        .OUTPUT_COUNT  (OUT),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .selectors  (selectors),
        .enabled_out(enabled_out),
        .cmd_done   (cmd_done),
        .cmd_err    (cmd_err),
        .err_code   (err_code),
        .dirty      (dirty)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;
    int done_cnt = 0;
    int err_cnt = 0;
    int last_code = 0;

    // Reference model: shadow/live tables plus a byte-level command parser.
    int unsigned m_sh_sel[OUT];
    bit          m_sh_en[OUT];
    int unsigned m_lv_sel[OUT];
    bit          m_lv_en[OUT];
    bit          m_done, m_err;
    int unsigned m_code;
    logic [7:0]  cmd_q[$];
    int unsigned idle_cnt;
    bit          pend;
    bit          pend_tmo;
    logic [7:0]  pend_op, pend_o, pend_s;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] exp_sel();
        logic [63:0] r = '0;
        for (int i = 0; i < OUT; i++) r = r | (64'(m_lv_sel[i]) << (i * SW));
        return r;
    endfunction

    function automatic logic [OUT-1:0] exp_en();
        logic [OUT-1:0] r = '0;
        for (int i = 0; i < OUT; i++) r[i] = m_lv_en[i];
        return r;
    endfunction

    function automatic bit exp_dirty();
        for (int i = 0; i < OUT; i++)
            if (m_sh_sel[i] != m_lv_sel[i] || m_sh_en[i] != m_lv_en[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int cmd_len(input logic [7:0] op);
        if (op == 8'h01) return 3;
        if (op == 8'h02) return 2;
        return 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < OUT; i++) begin
            m_sh_sel[i] = 0; m_sh_en[i] = 0; m_lv_sel[i] = 0; m_lv_en[i] = 0;
        end
        m_done = 0; m_err = 0; m_code = 0;
        cmd_q.delete(); idle_cnt = 0; pend = 0; pend_tmo = 0;
    endtask

    task automatic model_apply();
        if (pend_tmo) begin
            m_err = 1; m_code = 3;
        end else if (pend_op == 8'h01) begin
            if (pend_o < OUT && pend_s < IN) begin
                m_sh_sel[pend_o] = pend_s % IN; m_sh_en[pend_o] = 1; m_done = 1;
            end else begin
                m_err = 1; m_code = 2;
            end
        end else if (pend_op == 8'h02) begin
            if (pend_o < OUT) begin
                m_sh_en[pend_o] = 0; m_done = 1;
            end else begin
                m_err = 1; m_code = 2;
            end
        end else if (pend_op == 8'h03) begin
            for (int i = 0; i < OUT; i++) begin
                m_lv_sel[i] = m_sh_sel[i]; m_lv_en[i] = m_sh_en[i];
            end
            m_done = 1;
        end else if (pend_op == 8'h04) begin
            for (int i = 0; i < OUT; i++) begin
                m_sh_sel[i] = 0; m_sh_en[i] = 0;
            end
            m_done = 1;
        end else begin
            m_err = 1; m_code = 1;
        end
    endtask

    // One model step per clock edge; a full command resolves one edge after its last byte.
    task automatic model_step();
        m_done = 0; m_err = 0; m_code = 0;
        if (pend) begin
            model_apply();
            pend = 0;
        end else if (in_valid) begin
            cmd_q.push_back(in_data);
            idle_cnt = 0;
            if (cmd_q.size() == cmd_len(cmd_q[0])) begin
                pend_op = cmd_q[0];
                pend_o  = (cmd_q.size() > 1) ? cmd_q[1] : 8'h00;
                pend_s  = (cmd_q.size() > 2) ? cmd_q[2] : 8'h00;
                pend_tmo = 0; pend = 1;
                cmd_q.delete();
            end
        end else if (cmd_q.size() > 0) begin
            idle_cnt++;
            if (idle_cnt == TMO) begin
                pend_tmo = 1; pend = 1;
                cmd_q.delete();
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                check("selectors", selectors, exp_sel());
                check("enabled_out", 64'(enabled_out), 64'(exp_en()));
                check("dirty", 64'(dirty), 64'(exp_dirty()));
                check("in_ready", 64'(in_ready), 64'(!pend));
                check("cmd_done", 64'(cmd_done), 64'(m_done));
                check("cmd_err", 64'(cmd_err), 64'(m_err));
                check("err_code", 64'(err_code), 64'(m_code));
                if (cmd_done === 1'b1) done_cnt++;
                if (cmd_err === 1'b1) begin
                    err_cnt++;
                    last_code = int'(err_code);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int tries = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && tries < 8) begin
            @(negedge clk);
            tries++;
        end
        if (tries >= 8) begin
            checks++;
            errors++;
            $display("FAIL handshake: byte %0h not accepted within 8 cycles, expected accept", b);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
        #2;
    endtask

    initial begin
        int d0;
        #1 rst_n = 1'b0;
        started = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        idle(10);
        check("rst_sel", selectors, 64'h0);
        check("rst_en", 64'(enabled_out), 64'h0);
        check("rst_dirty", 64'(dirty), 64'h0);
        check("rst_pulses", 64'(done_cnt + err_cnt), 64'h0);

        send_byte(8'h01); send_byte(8'h03); send_byte(8'h0F); idle(3);
        check("set_dirty", 64'(dirty), 64'h1);
        check("set_live_en", 64'(enabled_out), 64'h0);
        send_byte(8'h03); idle(3);
        check("commit_sel", selectors, 64'h0000_0000_0000_F000);
        check("commit_en", 64'(enabled_out), 64'h0008);
        check("commit_dirty", 64'(dirty), 64'h0);
        check("commit_done_cnt", 64'(done_cnt), 64'd2);

        send_byte(8'h01); send_byte(8'h10); send_byte(8'h02); idle(3);
        check("range_o_cnt", 64'(err_cnt), 64'd1);
        check("range_o_code", 64'(last_code), 64'd2);
        check("range_o_dirty", 64'(dirty), 64'h0);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h10); idle(3);
        check("range_s_cnt", 64'(err_cnt), 64'd2);
        check("range_s_code", 64'(last_code), 64'd2);

        send_byte(8'h7A); send_byte(8'h04); idle(3);
        check("badop_code", 64'(last_code), 64'd1);
        check("badop_next_done", 64'(done_cnt), 64'd3);
        check("clear_dirty", 64'(dirty), 64'h1);
        send_byte(8'h03); idle(3);
        check("clear_commit_en", 64'(enabled_out), 64'h0);

        send_byte(8'h01); send_byte(8'h05); idle(12);
        check("tmo_cnt", 64'(err_cnt), 64'd4);
        check("tmo_code", 64'(last_code), 64'd3);
        check("tmo_dirty", 64'(dirty), 64'h0);
        d0 = done_cnt;
        send_byte(8'h01); send_byte(8'h05); idle(7); send_byte(8'h0A); idle(3);
        check("edge_no_err", 64'(err_cnt), 64'd4);
        check("edge_done", 64'(done_cnt - d0), 64'd1);
        send_byte(8'h02); send_byte(8'h05); idle(3);
        check("dis_keeps_sel_dirty", 64'(dirty), 64'h1);
        send_byte(8'h03); idle(3);
        check("dis_commit_sel", selectors, 64'h0000_0000_00A0_0000);
        check("dis_commit_en", 64'(enabled_out), 64'h0);

        send_byte(8'h01); send_byte(8'h00); send_byte(8'h01); send_byte(8'h03); idle(3);
        check("set0_sel", selectors, 64'h0000_0000_00A0_0001);
        check("set0_en", 64'(enabled_out), 64'h0001);
        send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
        @(negedge clk);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_sel", selectors, 64'h0);
        check("rst_mid_en", 64'(enabled_out), 64'h0);
        d0 = done_cnt + err_cnt;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        idle(6);
        check("rst_mid_no_pulse", 64'(done_cnt + err_cnt), 64'(d0));
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h03); idle(3);
        check("post_rst_sel", selectors, 64'h0000_0000_0000_0300);
        check("post_rst_en", 64'(enabled_out), 64'h0004);
        d0 = done_cnt;
        send_byte(8'h03); idle(3);
        check("clean_commit_done", 64'(done_cnt - d0), 64'd1);
        check("clean_commit_sel", selectors, 64'h0000_0000_0000_0300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
